operand_b_sel: RTL and testbench

- Operand-B selection stage of the RV32 execute path.
- Combinationally selects the ALU second operand: register-file rs2 data when Bsel=0, or the sign-extended immediate when Bsel=1.
- Also provides a registered copy of the selected operand, the raw rs2 value (store data) and the select bit, for the next pipeline stage, with stall and flush control.

---
 rtl/operand_b_sel.sv | 98 +++++++++
 tb/tb_operand_b_sel.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_b_sel.sv
// -----------------------------------------------------------------------------
// operand_b_sel
//
// Operand-B selection stage of the RV32 execute path.
//
// The ALU second operand is chosen combinationally:
//   - Bsel = 0 selects the register-file rs2 data.
//   - Bsel = 1 selects the already-extended immediate.
//
// A pipeline register also captures three values for the next stage:
//   - the selected operand,
//   - the raw rs2 value, used as store data,
//   - the select bit.
//
// The register has a valid flag and supports stall and flush.
//
// Ports:
//   clk          in   rising-edge clock (pipeline register only)
//   rst          in   synchronous active-high reset
//   reg_data2    in   [XLEN-1:0] rs2 read data
//   imm_data     in   [XLEN-1:0] extended immediate
//   Bsel         in   operand-B select (0 = reg_data2, 1 = imm_data)
//   en           in   pipeline-register load enable (0 = hold)
//   flush        in   synchronous bubble insert
//   operandB     out  [XLEN-1:0] combinational selected operand
//   operandB_q   out  [XLEN-1:0] registered operandB
//   store_data_q out  [XLEN-1:0] registered reg_data2, independent of Bsel
//   bsel_q       out  registered Bsel
//   valid_q      out  register holds a loaded, non-flushed entry
// -----------------------------------------------------------------------------
module operand_b_sel #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] reg_data2,
   input  logic [XLEN-1:0] imm_data,
   input  logic            Bsel,
   input  logic            en,
   input  logic            flush,
   output logic [XLEN-1:0] operandB,
   output logic [XLEN-1:0] operandB_q,
   output logic [XLEN-1:0] store_data_q,
   output logic            bsel_q,
   output logic            valid_q
);

   logic [XLEN-1:0] operand_b_s;
   logic [XLEN-1:0] operand_b_q_r;
   logic [XLEN-1:0] store_data_q_r;
   logic            bsel_q_r;
   logic            valid_q_r;

   // Operand-B mux.
   // Full-width, bit-exact pass-through with no extension.
   // An unknown Bsel falls to the rs2 branch, so no latch is inferred.
   always_comb begin
      operand_b_s = reg_data2;
      if (Bsel == 1'b1) begin
         operand_b_s = imm_data;
      end else begin
         operand_b_s = reg_data2;
      end
   end

   // Pipeline register.
   // Priority is rst, then flush, then en. With en low, every field holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         operand_b_q_r  <= {XLEN{1'b0}};
         store_data_q_r <= {XLEN{1'b0}};
         bsel_q_r       <= 1'b0;
         valid_q_r      <= 1'b0;
      end else if (flush) begin
         operand_b_q_r  <= {XLEN{1'b0}};
         store_data_q_r <= {XLEN{1'b0}};
         bsel_q_r       <= 1'b0;
         valid_q_r      <= 1'b0;
      end else if (en) begin
         operand_b_q_r  <= operand_b_s;
         store_data_q_r <= reg_data2;
         bsel_q_r       <= Bsel;
         valid_q_r      <= 1'b1;
      end else begin
         operand_b_q_r  <= operand_b_q_r;
         store_data_q_r <= store_data_q_r;
         bsel_q_r       <= bsel_q_r;
         valid_q_r      <= valid_q_r;
      end
   end

   assign operandB     = operand_b_s;
   assign operandB_q   = operand_b_q_r;
   assign store_data_q = store_data_q_r;
   assign bsel_q       = bsel_q_r;
   assign valid_q      = valid_q_r;

endmodule

// File: tb/tb_operand_b_sel.sv
// -----------------------------------------------------------------------------
// tb_operand_b_sel
//
// Directed, table-driven bench for operand_b_sel.
//
// The bench runs in two parts:
//   - Combinational checks of the mux, made before the first clock edge.
//   - A table of clocked vectors. Each vector is driven on the falling edge.
//
// For each vector the bench compares, in order:
//   1. operandB, immediately after the inputs are driven.
//   2. The registered outputs before the rising edge, which must still hold
//      the previous values.
//   3. The registered outputs after the rising edge, against hand-computed
//      values.
// -----------------------------------------------------------------------------
module tb_operand_b_sel;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst;
   logic [XLEN-1:0] reg_data2;
   logic [XLEN-1:0] imm_data;
   logic            Bsel;
   logic            en;
   logic            flush;
   logic [XLEN-1:0] operandB;
   logic [XLEN-1:0] operandB_q;
   logic [XLEN-1:0] store_data_q;
   logic            bsel_q;
   logic            valid_q;

   int errors;
   int checks;

   operand_b_sel #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .reg_data2    (reg_data2),
      .imm_data     (imm_data),
      .Bsel         (Bsel),
      .en           (en),
      .flush        (flush),
      .operandB     (operandB),
      .operandB_q   (operandB_q),
      .store_data_q (store_data_q),
      .bsel_q       (bsel_q),
      .valid_q      (valid_q)
   );

   // Clock generation. The first rising edge is at t=10, which leaves room
   // for the clock-free mux checks.
   initial begin
      clk = 1'b0;
      #5;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic            rst;
      logic            flush;
      logic            en;
      logic            bsel;
      logic [XLEN-1:0] reg_d;
      logic [XLEN-1:0] imm_d;
      logic [XLEN-1:0] exp_opb;
      logic [XLEN-1:0] exp_opb_q;
      logic [XLEN-1:0] exp_sd_q;
      logic            exp_bsel_q;
      logic            exp_valid_q;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [XLEN-1:0] actual,
                        input logic [XLEN-1:0] required);
      checks = checks + 1;
      if (actual !== required) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, expected %h", name, actual, required);
      end
   endtask

   task automatic check_regs(input string tag, input logic [XLEN-1:0] e_opb_q,
                             input logic [XLEN-1:0] e_sd_q, input logic e_bsel_q,
                             input logic e_valid_q);
      check({tag, " operandB_q"}, operandB_q, e_opb_q);
      check({tag, " store_data_q"}, store_data_q, e_sd_q);
      check({tag, " bsel_q"}, {31'd0, bsel_q}, {31'd0, e_bsel_q});
      check({tag, " valid_q"}, {31'd0, valid_q}, {31'd0, e_valid_q});
   endtask

   initial begin
      logic [XLEN-1:0] prev_opb_q;
      logic [XLEN-1:0] prev_sd_q;
      logic            prev_bsel_q;
      logic            prev_valid_q;

      errors = 0;
      checks = 0;

      // Vector fields, in order:
      //   rst flush en bsel reg imm | opB | opB_q sd_q bsel_q valid_q
      // Reset release; the first load is with Bsel = 1.
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd100, 32'd300, 32'd100,
                   32'd0, 32'd0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd100, 32'd300, 32'd300,
                   32'd300, 32'd100, 1'b1, 1'b1};
      // Load 100 via Bsel = 0, then stall for three edges with new inputs.
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd100, 32'd300, 32'd100,
                   32'd100, 32'd100, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd55, 32'd7, 32'd7,
                   32'd100, 32'd100, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd55, 32'd7, 32'd7,
                   32'd100, 32'd100, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd55, 32'd7, 32'd7,
                   32'd100, 32'd100, 1'b0, 1'b1};
      // Resume; store data follows rs2 even though the immediate is selected.
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd55, 32'd7, 32'd7,
                   32'd7, 32'd55, 1'b1, 1'b1};
      // Flush with en = 0.
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd55, 32'd7, 32'd7,
                   32'd0, 32'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd9, 32'd1, 32'd9,
                   32'd9, 32'd9, 1'b0, 1'b1};
      // Flush with en = 1.
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd9, 32'd1, 32'd9,
                   32'd0, 32'd0, 1'b0, 1'b0};
      // Load a negative immediate, bit-exact.
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd5, 32'hFFFF_F800, 32'hFFFF_F800,
                   32'hFFFF_F800, 32'd5, 1'b1, 1'b1};
      // Reset mid-operation overrides en.
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 32'hFFFF_F800, 32'hFFFF_F800,
                   32'd0, 32'd0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 32'd4, 32'd3,
                   32'd0, 32'd0, 1'b0, 1'b0};
      // Reset released with en = 0: nothing loads.
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd3,
                   32'd0, 32'd0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1};

      // Combinational mux, before any clock edge.
      rst       = 1'b1;
      flush     = 1'b0;
      en        = 1'b1;
      Bsel      = 1'b0;
      reg_data2 = 32'd100;
      imm_data  = 32'd300;
      #5;
      check("mux rs2", operandB, 32'd100);
      Bsel = 1'b1;
      #1;
      check("mux imm", operandB, 32'd300);
      imm_data  = 32'hFFFF_F800;
      reg_data2 = 32'd5;
      #1;
      check("mux neg imm", operandB, 32'hFFFF_F800);
      Bsel      = 1'b0;
      reg_data2 = 32'hFFFF_FFFF;
      #1;
      check("mux all ones rs2", operandB, 32'hFFFF_FFFF);
      Bsel      = 1'b0;
      reg_data2 = 32'd100;
      imm_data  = 32'd300;

      // The edge at t=10 occurs with rst = 1, so everything is cleared.
      @(posedge clk);
      #1;
      prev_opb_q   = 32'd0;
      prev_sd_q    = 32'd0;
      prev_bsel_q  = 1'b0;
      prev_valid_q = 1'b0;
      check_regs("first reset edge", prev_opb_q, prev_sd_q, prev_bsel_q,
                 prev_valid_q);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst       = vecs[i].rst;
         flush     = vecs[i].flush;
         en        = vecs[i].en;
         Bsel      = vecs[i].bsel;
         reg_data2 = vecs[i].reg_d;
         imm_data  = vecs[i].imm_d;
         #1;
         check($sformatf("v%0d operandB", i), operandB, vecs[i].exp_opb);
         check_regs($sformatf("v%0d pre-edge", i), prev_opb_q, prev_sd_q,
                    prev_bsel_q, prev_valid_q);
         @(posedge clk);
         #1;
         check_regs($sformatf("v%0d post-edge", i), vecs[i].exp_opb_q,
                    vecs[i].exp_sd_q, vecs[i].exp_bsel_q,
                    vecs[i].exp_valid_q);
         prev_opb_q   = vecs[i].exp_opb_q;
         prev_sd_q    = vecs[i].exp_sd_q;
         prev_bsel_q  = vecs[i].exp_bsel_q;
         prev_valid_q = vecs[i].exp_valid_q;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
